// File: rtl/pwm_audio_output.sv
// Sample-paced PWM audio driver: 2-entry sample FIFO, fixed-period PWM, underrun detection.
// Build option: define PWM_UNDERRUN_MUTE_EN to silence the output on underrun instead of holding the last sample.
module pwm_audio_output #(
  parameter int WIDTH  = 9,
  parameter int PERIOD = 512
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  output logic             o_pwm,
  output logic             o_period_stb,
  output logic             o_underrun,
  output logic [7:0]       o_underrun_count,
  output logic [1:0]       o_level
);

  localparam int CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int CMPW = (WIDTH > CW) ? WIDTH : CW;
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_cmp;
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr, wr_ptr;
  logic             load, empty, push, pop;

  assign load           = (r_cnt == CNT_MAX);
  assign empty          = (o_level == 2'd0);
  assign o_sample_ready = (o_level != 2'd2);
  assign push           = i_sample_valid && o_sample_ready;
  assign pop            = load && !empty;
  assign o_period_stb   = (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= CNT_MAX;
    end else begin
      r_cnt <= load ? '0 : r_cnt + 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; the level and pointers alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_sample;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      o_level <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   o_level <= o_level + 2'd1;
        2'b01:   o_level <= o_level - 2'd1;
        default: o_level <= o_level;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    if (state == IDLE && pop) state_next = RUN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmp            <= '0;
      o_underrun       <= 1'b0;
      o_underrun_count <= 8'd0;
    end else begin
      o_underrun <= 1'b0;
      if (load) begin
        if (!empty) begin
          r_cmp <= mem[rd_ptr];
        end else if (state == IDLE) begin
          r_cmp <= '0;
        end else begin
          // Producer fell behind: flag it for the cycle that starts the new period.
          o_underrun <= 1'b1;
          if (o_underrun_count != 8'hFF) o_underrun_count <= o_underrun_count + 8'd1;
`ifdef PWM_UNDERRUN_MUTE_EN
          r_cmp <= '0;
`else
          r_cmp <= r_cmp;
`endif
        end
      end
    end
  end

  // Comparing at the wider of the two widths lets r_cmp >= PERIOD give a fully-high period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_pwm <= 1'b0;
    else          o_pwm <= (CMPW'(r_cnt) < CMPW'(r_cmp));
  end

endmodule

// File: tb/tb_pwm_audio_output.sv
// Scoreboard bench for pwm_audio_output: a 512-cycle instance and a 16-cycle instance.
// Stimulus queues one expected record per period strobe; per-instance monitors measure and compare.
`timescale 1ns/1ps
module tb_pwm_audio_output;

  localparam int PA = 512;
  localparam int PB = 16;
`ifdef PWM_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  typedef struct {
    int high;
    int und;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n;
  logic [8:0] a_sample, b_sample;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready, a_pwm, b_pwm, a_stb, b_stb, a_und, b_und;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] a_level, b_level;

  pwm_audio_output #(.WIDTH(9), .PERIOD(PA)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_sample(a_sample), .i_sample_valid(a_valid),
    .o_sample_ready(a_ready), .o_pwm(a_pwm), .o_period_stb(a_stb), .o_underrun(a_und),
    .o_underrun_count(a_cnt), .o_level(a_level)
  );

  pwm_audio_output #(.WIDTH(9), .PERIOD(PB)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .i_sample(b_sample), .i_sample_valid(b_valid),
    .o_sample_ready(b_ready), .o_pwm(b_pwm), .o_period_stb(b_stb), .o_underrun(b_und),
    .o_underrun_count(b_cnt), .o_level(b_level)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int high, input int und, input int cnt);
    exp_t e;
    e.high = high;
    e.und  = und;
    e.cnt  = cnt;
    return e;
  endfunction

  // Monitor A: a window runs from the cycle after one strobe through the next strobe cycle.
  int acc_a, cyc_a;
  bit seen_a;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a_n) begin
      acc_a = 0; cyc_a = 0; seen_a = 1'b0;
    end else begin
      acc_a += int'(a_pwm);
      cyc_a++;
      if (a_stb) begin
        if (seen_a) check("a_stb_spacing", cyc_a, PA);
        if (q_a.size() == 0) begin
          check("a_unexpected_period", q_a.size(), 1);
        end else begin
          e = q_a.pop_front();
          check("a_high_cycles", acc_a, e.high);
          check("a_underrun", int'(a_und), e.und);
          check("a_underrun_count", int'(a_cnt), e.cnt);
        end
        acc_a = 0; cyc_a = 0; seen_a = 1'b1;
      end else begin
        check("a_underrun_off_stb", int'(a_und), 0);
      end
    end
  end

  int acc_b, cyc_b;
  bit seen_b;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_b_n) begin
      acc_b = 0; cyc_b = 0; seen_b = 1'b0;
    end else begin
      acc_b += int'(b_pwm);
      cyc_b++;
      if (b_stb) begin
        if (seen_b) check("b_stb_spacing", cyc_b, PB);
        if (q_b.size() == 0) begin
          check("b_unexpected_period", q_b.size(), 1);
        end else begin
          e = q_b.pop_front();
          check("b_high_cycles", acc_b, e.high);
          check("b_underrun", int'(b_und), e.und);
          check("b_underrun_count", int'(b_cnt), e.cnt);
        end
        acc_b = 0; cyc_b = 0; seen_b = 1'b1;
      end else begin
        check("b_underrun_off_stb", int'(b_und), 0);
      end
    end
  end

  task automatic wait_drain(input bit b, input int budget);
    int n = 0;
    while ((b ? q_b.size() : q_a.size()) != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(b ? "b_drain" : "a_drain", b ? q_b.size() : q_a.size(), 0);
  endtask

  // Presents v with valid held until the handshake edge; reports whether that cycle was a strobe cycle.
  task automatic send(input bit b, input int v, output bit stb_at);
    int n = 0;
    if (b) begin b_sample = 9'(v); b_valid = 1'b1; end
    else   begin a_sample = 9'(v); a_valid = 1'b1; end
    while (!(b ? b_ready : a_ready) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check(b ? "b_send_ready" : "a_send_ready", int'(b ? b_ready : a_ready), 1);
    stb_at = b ? b_stb : a_stb;
    @(posedge clk); #1;
  endtask

  initial begin
    bit stb_at;
    int hold128, hold100, hold20;
    hold128 = MUTE ? 0 : 128;
    hold100 = MUTE ? 0 : 100;
    hold20  = MUTE ? 0 : PB;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_sample = '0; b_sample = '0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pwm", int'(a_pwm), 0);
    check("rst_stb", int'(a_stb), 0);
    check("rst_underrun", int'(a_und), 0);
    check("rst_count", int'(a_cnt), 0);
    check("rst_level", int'(a_level), 0);
    check("rst_ready", int'(a_ready), 1);

    // Idle for four full periods: all strobes, no drive, no underruns.
    for (int i = 0; i < 5; i++) q_a.push_back(mk(0, 0, 0));
    rst_a_n = 1'b1;
    wait_drain(1'b0, 2100);
    check("idle_ready", int'(a_ready), 1);

    // Single sample pushed while idle, then starvation.
    q_a.push_back(mk(0, 0, 0));
    q_a.push_back(mk(128, 1, 1));
    q_a.push_back(mk(hold128, 1, 2));
    send(1'b0, 128, stb_at);
    a_valid = 1'b0;
    check("one_sample_level", int'(a_level), 1);
    wait_drain(1'b0, 3 * PA + 10);

    // Back-to-back 300, 200, 100 with valid held.
    q_a.push_back(mk(hold128, 0, 2));
    q_a.push_back(mk(300, 0, 2));
    q_a.push_back(mk(200, 0, 2));
    q_a.push_back(mk(100, 1, 3));
    send(1'b0, 300, stb_at);
    send(1'b0, 200, stb_at);
    check("full_level", int'(a_level), 2);
    check("full_ready", int'(a_ready), 0);
    send(1'b0, 100, stb_at);
    a_valid = 1'b0;
    check("third_accept_at_stb", int'(stb_at), 1);
    check("third_level", int'(a_level), 2);
    wait_drain(1'b0, 4 * PA + 10);

    // Two more underruns, refill, then reset mid-period.
    q_a.push_back(mk(hold100, 1, 4));
    q_a.push_back(mk(hold100, 1, 5));
    wait_drain(1'b0, 2 * PA + 10);
    send(1'b0, 50, stb_at);
    send(1'b0, 60, stb_at);
    a_valid = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("pre_rst_level", int'(a_level), 2);
    check("pre_rst_count", int'(a_cnt), 5);
    check("pre_rst_pwm", int'(a_pwm), MUTE ? 0 : 1);
    #1 rst_a_n = 1'b0;
    #1;
    check("mid_rst_pwm", int'(a_pwm), 0);
    check("mid_rst_level", int'(a_level), 0);
    check("mid_rst_count", int'(a_cnt), 0);
    check("mid_rst_ready", int'(a_ready), 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) q_a.push_back(mk(0, 0, 0));
    #1 rst_a_n = 1'b1;
    wait_drain(1'b0, 2 * PA + 20);
    rst_a_n = 1'b0;

    // Short-period instance: samples 0, 15, 20, then 300 starved periods.
    @(negedge clk);
    q_b.push_back(mk(0, 0, 0));
    #1 rst_b_n = 1'b1;
    wait_drain(1'b1, 40);
    q_b.push_back(mk(0, 0, 0));
    q_b.push_back(mk(0, 0, 0));
    q_b.push_back(mk(15, 0, 0));
    for (int k = 1; k <= 300; k++)
      q_b.push_back(mk((k == 1) ? PB : hold20, 1, (k > 255) ? 255 : k));
    send(1'b1, 0, stb_at);
    send(1'b1, 15, stb_at);
    check("b_full_level", int'(b_level), 2);
    send(1'b1, 20, stb_at);
    b_valid = 1'b0;
    check("b_third_accept_at_stb", int'(stb_at), 1);
    wait_drain(1'b1, 310 * PB);
    check("b_count_saturated", int'(b_cnt), 255);
    rst_b_n = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
